// File: rtl/round_timer_pkg.sv
// round_timer_pkg: shared constants and state type for the round timer
package round_timer_pkg;
    localparam int SEC_W_DEF     = 6;
    localparam int DEFAULT_SECS  = 30;
    localparam int WARN_SECS     = 5;
    localparam int TICKS_PER_SEC = 10;
    localparam int TEN_W         = 4;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;
endpackage

// File: rtl/round_tick_div.sv
// round_tick_div: tenths counter with enable, sync clear and terminal-count pulse
module round_tick_div #(
    parameter int TICKS = 10,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         tc
);
    assign tc = en && cnt == W'(TICKS - 1);
    // count enabled ticks, wrap at the terminal count, clear has priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= tc ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/round_timer_ctrl.sv
// round_timer_ctrl: per-round countdown built from 100 ms ticks
module round_timer_ctrl #(
    parameter int SEC_W         = round_timer_pkg::SEC_W_DEF,
    parameter int DEFAULT_SECS  = round_timer_pkg::DEFAULT_SECS,
    parameter int WARN_SECS     = round_timer_pkg::WARN_SECS,
    parameter int TICKS_PER_SEC = round_timer_pkg::TICKS_PER_SEC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_100ms,
    input  logic             start,
    input  logic             pause_tgl,
    input  logic             abort,
    input  logic             load_en,
    input  logic [SEC_W-1:0] load_secs,
    output logic [SEC_W-1:0] secs_left,
    output logic [3:0]       tenths,
    output logic             running,
    output logic             paused,
    output logic             warn,
    output logic             time_up,
    output logic             expired,
    output logic             prescale_clr
);
    import round_timer_pkg::*;
    state_t           state, state_nx;
    logic [SEC_W-1:0] preset, secs_nx;
    logic             start_ok, run_tick, last_tick, expire;
    assign start_ok = start && preset != '0;
    assign run_tick = tick_100ms && state == ST_RUN && !abort && !start_ok && !pause_tgl;
    assign expire   = last_tick && secs_left == SEC_W'(1);
    round_tick_div #(.TICKS(TICKS_PER_SEC), .W(4)) u_div (
        .clk (clk),
        .rst (rst),
        .en  (run_tick),
        .clr (abort || start_ok),
        .cnt (tenths),
        .tc  (last_tick)
    );
    // next state and seconds follow abort > start > pause_tgl > tick priority
    always_comb begin
        state_nx = abort ? ST_IDLE :
                   start_ok ? ST_RUN :
                   (pause_tgl && state == ST_RUN) ? ST_PAUSE :
                   (pause_tgl && state == ST_PAUSE) ? ST_RUN :
                   expire ? ST_EXPIRED : state;
        secs_nx  = abort ? '0 :
                   start_ok ? preset :
                   last_tick ? secs_left - 1'b1 : secs_left;
    end
    // register state, counters and every flag so outputs are glitch-free
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            preset       <= SEC_W'(DEFAULT_SECS);
            secs_left    <= '0;
            running      <= 1'b0;
            paused       <= 1'b0;
            warn         <= 1'b0;
            time_up      <= 1'b0;
            expired      <= 1'b0;
            prescale_clr <= 1'b0;
        end else begin
            state        <= state_nx;
            secs_left    <= secs_nx;
            running      <= state_nx == ST_RUN;
            paused       <= state_nx == ST_PAUSE;
            expired      <= state_nx == ST_EXPIRED;
            warn         <= (state_nx == ST_RUN || state_nx == ST_PAUSE) &&
                            secs_nx != '0 && secs_nx <= SEC_W'(WARN_SECS);
            time_up      <= expire;
            prescale_clr <= start_ok && !abort;
            if (load_en && (state == ST_IDLE || state == ST_EXPIRED)) preset <= load_secs;
        end
    end
endmodule

// File: tb/tb_round_timer_ctrl.sv
// tb_round_timer_ctrl: directed plan plus random stimulus against an elapsed-tick model
module tb_round_timer_ctrl;
    localparam int TPS = 10;
    logic       clk, rst, tick_100ms, start, pause_tgl, abort, load_en;
    logic [5:0] load_secs, secs_left;
    logic [3:0] tenths;
    logic       running, paused, warn, time_up, expired, prescale_clr;
    int checks = 0, errors = 0;
    // model: mode 0 idle, 1 run, 2 pause, 3 expired; round tracked as elapsed ticks
    int m_mode, m_preset, m_len, m_el, m_tu, m_pc;

    round_timer_ctrl dut (
        .clk(clk), .rst(rst), .tick_100ms(tick_100ms), .start(start),
        .pause_tgl(pause_tgl), .abort(abort), .load_en(load_en),
        .load_secs(load_secs), .secs_left(secs_left), .tenths(tenths),
        .running(running), .paused(paused), .warn(warn), .time_up(time_up),
        .expired(expired), .prescale_clr(prescale_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_preset = 30; m_len = 0; m_el = 0; m_tu = 0; m_pc = 0;
    endtask

    task automatic model(input bit a, s, p, t, le, input int ls);
        int old_mode;
        old_mode = m_mode;
        m_tu = 0;
        m_pc = 0;
        if (a) begin
            m_mode = 0; m_len = 0; m_el = 0;
        end else if (s && m_preset != 0) begin
            m_mode = 1; m_len = m_preset * TPS; m_el = 0; m_pc = 1;
        end else if (p && (m_mode == 1 || m_mode == 2)) begin
            m_mode = 3 - m_mode;
        end else if (t && m_mode == 1) begin
            m_el++;
            if (m_el == m_len) begin
                m_mode = 3; m_tu = 1;
            end
        end
        if (le && (old_mode == 0 || old_mode == 3)) m_preset = ls;
    endtask

    task automatic check_all();
        int s;
        s = m_len / TPS - m_el / TPS;
        check("secs_left", secs_left, s);
        check("tenths", tenths, m_el % TPS);
        check("running", running, m_mode == 1);
        check("paused", paused, m_mode == 2);
        check("expired", expired, m_mode == 3);
        check("warn", warn, (m_mode == 1 || m_mode == 2) && s >= 1 && s <= 5);
        check("time_up", time_up, m_tu);
        check("prescale_clr", prescale_clr, m_pc);
    endtask

    task automatic cyc(input bit a, s, p, t, le, input int ls);
        @(negedge clk);
        abort = a; start = s; pause_tgl = p; tick_100ms = t; load_en = le;
        load_secs = 6'(ls);
        model(a, s, p, t, le, ls);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        rst = 1'b0; tick_100ms = 0; start = 0; pause_tgl = 0; abort = 0;
        load_en = 0; load_secs = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_secs", secs_left, 0);
        check("rst_flags", {running, paused, warn, time_up, expired, prescale_clr}, 0);
        check_all();
        @(negedge clk) rst = 1'b1;

        // 3 s round to expiry
        cyc(0, 0, 0, 0, 1, 3);
        cyc(0, 1, 0, 0, 0, 0);
        check("t1_pclr", prescale_clr, 1);
        check("t1_secs0", secs_left, 3);
        for (int i = 1; i <= 30; i++) begin
            cyc(0, 0, 0, 1, 0, 0);
            if (i == 10) check("t1_secs2", secs_left, 2);
            if (i == 20) check("t1_secs1", secs_left, 1);
            if (i < 30) check("t1_warn", warn, 1);
        end
        check("t1_secs_end", secs_left, 0);
        check("t1_time_up", time_up, 1);
        check("t1_expired", expired, 1);
        cyc(0, 0, 0, 0, 0, 0);
        check("t1_time_up_once", time_up, 0);
        check("t1_expired_hold", expired, 1);
        ticks(12);
        check("t1_no_wrap", secs_left, 0);

        // pause and resume on a 30 s round
        cyc(0, 0, 0, 0, 1, 30);
        cyc(0, 1, 0, 0, 0, 0);
        ticks(15);
        cyc(0, 0, 1, 0, 0, 0);
        check("t2_paused", paused, 1);
        ticks(20);
        check("t2_hold_secs", secs_left, 29);
        check("t2_hold_tenths", tenths, 5);
        cyc(0, 0, 1, 0, 0, 0);
        ticks(5);
        check("t2_secs", secs_left, 28);
        check("t2_tenths", tenths, 0);

        // simultaneous events
        cyc(0, 1, 0, 1, 0, 0);
        check("sim_start_tick", tenths, 0);
        ticks(3);
        cyc(0, 0, 1, 1, 0, 0);
        check("sim_pause_tick", tenths, 3);
        check("sim_pause_state", paused, 1);
        cyc(1, 1, 0, 0, 0, 0);
        check("sim_abort_start", running, 0);
        check("sim_abort_secs", secs_left, 0);

        // preset handling
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0);
        check("zero_preset_run", running, 0);
        check("zero_preset_pclr", prescale_clr, 0);
        cyc(0, 0, 0, 0, 1, 7);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 4);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        check("load_in_run", secs_left, 7);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 2);
        check("load_with_start", secs_left, 7);

        // restart at 12.7 s
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 30);
        cyc(0, 1, 0, 0, 0, 0);
        ticks(187);
        check("rs_secs_pre", secs_left, 12);
        check("rs_tenths_pre", tenths, 7);
        cyc(0, 1, 0, 0, 0, 0);
        check("rs_secs", secs_left, 30);
        check("rs_tenths", tenths, 0);
        check("rs_pclr", prescale_clr, 1);

        // asynchronous reset mid-round
        ticks(13);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst_secs", secs_left, 0);
        check("arst_tenths", tenths, 0);
        check("arst_flags", {running, paused, warn, time_up, expired, prescale_clr}, 0);
        @(negedge clk) rst = 1'b1;
        model_reset();
        cyc(0, 1, 0, 0, 0, 0);
        check("arst_preset", secs_left, 30);

        // random traffic with short presets so rounds expire often
        cyc(1, 0, 0, 0, 1, 3);
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(99) < 2, $urandom_range(99) < 4,
                $urandom_range(99) < 4, $urandom_range(99) < 45,
                $urandom_range(99) < 5, $urandom_range(8));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/round_timer_ctrl.md
Name: round_timer_ctrl

Overview:
- Sequences the game's 100 ms / 1 s timing chain into a per-round countdown.
- Start, pause/resume, abort and preset-load are driven by the game FSM. The block counts 100 ms ticks into seconds and flags the warning window and timeout.
- Sits between the 100 ms prescaler and the game controller / display driver. It also issues a clear pulse so the upstream prescaler phase-aligns to round start.

Parameters:
- SEC_W, 6, width of the seconds counter and preset.
- DEFAULT_SECS, 30, preset value after reset.
- WARN_SECS, 5, warn asserts while secs_left is 1..WARN_SECS.
- TICKS_PER_SEC, 10, number of tick_100ms pulses per second.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset; all state clears while low.
- tick_100ms  input  1  one-cycle pulse from the prescaler.
- start  input  1  one-cycle pulse; begins or restarts a round.
- pause_tgl  input  1  one-cycle pulse; toggles RUN/PAUSE.
- abort  input  1  one-cycle pulse; returns to IDLE.
- load_en  input  1  writes load_secs into the preset register.
- load_secs  input  SEC_W  new preset value.
- secs_left  output  SEC_W  remaining whole seconds.
- tenths  output  4  ticks elapsed in the current second, 0..TICKS_PER_SEC-1.
- running  output  1  high in RUN.
- paused  output  1  high in PAUSE.
- warn  output  1  low-time warning.
- time_up  output  1  one-cycle pulse on expiry.
- expired  output  1  high in EXPIRED.
- prescale_clr  output  1  one-cycle pulse to resync the upstream prescaler.

Behaviour:
- Reset values (rst low, asynchronous):
  - state = IDLE, preset = DEFAULT_SECS, secs_left = 0, tenths = 0.
  - running, paused, warn, time_up, expired and prescale_clr all 0.
- All outputs are registered.
- States: IDLE, RUN, PAUSE, EXPIRED. Per-cycle event priority: abort > start > pause_tgl > tick_100ms. Lower-priority events in the same cycle are dropped.
- abort, any state: next state IDLE, secs_left = 0, tenths = 0. A tick in the same cycle is ignored.
- start, any state, preset != 0:
  - Next state RUN, secs_left = preset, tenths = 0.
  - prescale_clr pulses the following cycle.
  - A tick in the same cycle is ignored.
  - A start in RUN or PAUSE is a restart.
- start with preset == 0: ignored; state and counters unchanged.
- load_en is honoured only in IDLE or EXPIRED, and takes effect next cycle. A start in the same cycle uses the old preset. load_en in RUN or PAUSE is ignored.
- RUN + tick_100ms:
  - tenths != TICKS_PER_SEC-1: tenths increments.
  - Otherwise tenths = 0 and secs_left decrements.
  - If secs_left was 1: secs_left = 0, state EXPIRED, time_up pulses for exactly one cycle, coincident with the cycle expired first goes high.
- RUN + pause_tgl: PAUSE. PAUSE + pause_tgl: RUN.
- In PAUSE, ticks are ignored; tenths and secs_left hold.
- pause_tgl in IDLE or EXPIRED: ignored.
- EXPIRED holds secs_left = 0 until start or abort. Counters never wrap below 0.
- warn = (RUN or PAUSE) and 1 <= secs_left <= WARN_SECS. It updates with the same registered timing as secs_left.
- Latency: a decrement is visible one cycle after the qualifying tick. Round length is preset × TICKS_PER_SEC ticks, measured from the first tick after start.

Decomposition:
- Shared package round_timer_pkg holds:
  - the state enum (IDLE, RUN, PAUSE, EXPIRED);
  - constants DEFAULT_SECS, WARN_SECS, TICKS_PER_SEC;
  - the SEC_W default.
- One sub-module, round_tick_div: a tenths counter with enable, sync clear and a terminal-count pulse output. The FSM, seconds counter, preset register and flags stay in round_timer_ctrl.

Test Plan:
- Reset, then load_secs=3 with load_en, then start, then 30 ticks. Required response:
  - prescale_clr pulses one cycle after start.
  - secs_left steps 3→2→1→0 at ticks 10, 20 and 30.
  - warn is high throughout (3 ≤ 5).
  - time_up is a single-cycle pulse at tick 30; expired stays high.
- Default preset 30, start, 15 ticks, pause_tgl, 20 ticks, pause_tgl, 5 ticks. Required response:
  - At the pause: secs_left = 29, tenths = 5; these hold through the 20 paused ticks.
  - After resume plus 5 ticks: secs_left = 28, tenths = 0.
- Simultaneous events:
  - start and tick in the same cycle: tick ignored, tenths = 0.
  - abort and start in the same cycle: IDLE, secs_left = 0.
  - pause_tgl and tick in RUN: PAUSE, tenths unchanged.
- Preset handling:
  - load_secs = 0 then start: stays IDLE, no prescale_clr.
  - load_en in RUN: ignored; the next round still uses the old preset.
  - load_en and start in the same cycle in IDLE: the round uses the old preset.
- Restart mid-round at secs_left = 12, tenths = 7: secs_left returns to preset, tenths = 0, prescale_clr pulses.
- rst low mid-RUN, asserted asynchronously between clock edges: all outputs clear immediately. After release the preset is DEFAULT_SECS = 30.
